// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: the VGA block prefetch always wins the port, and the
// remaining cycles go to the game write handshake or a sequenced whole-buffer clear.
module fb_arbiter #(
   parameter int PIX_W  = 4,
   parameter int FB_W   = 160,
   parameter int FB_H   = 120,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        col,
   input  logic [9:0]        row,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              clear_req,
   input  logic [PIX_W-1:0]  clear_color,
   output logic              busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [PIX_W-1:0]  mem_wdata,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic [PIX_W-1:0]  pixel,
   output logic [15:0]       wr_stall_cnt,
   output logic              wr_oob
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);
   localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_W * FB_H - 1);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [1:0]        state;
   logic [ADDR_W-1:0] clr_ptr;
   logic [PIX_W-1:0]  clr_color;
   logic [9:0]        ncol;
   logic [9:0]        nrow;
   logic              next_vis;
   logic              disp_slot;
   logic              vld_p1;
   logic [ADDR_W-1:0] disp_addr;
   logic              wr_fire;
   logic              wr_in_range;

   // Target two pixels ahead so the registered RAM read lands on the block boundary.
   always_comb begin
      if (col < 10'd798) begin
         nrow = row;
         ncol = col + 10'd2;
      end else begin
         nrow = (row == 10'd524) ? 10'd0 : row + 10'd1;
         ncol = 10'd0;
      end
   end

   assign next_vis  = (ncol < 10'd640) && (nrow < 10'd480);
   assign disp_slot = (col[1:0] == 2'd2) && next_vis;
   assign disp_addr = ADDR_W'(nrow[9:2]) * ADDR_W'(FB_W) + ADDR_W'(ncol[9:2]);

   assign wr_ready    = (state == ST_IDLE) && !disp_slot;
   assign wr_fire     = wr_valid && wr_ready;
   assign wr_in_range = wr_addr < FB_SIZE;
   assign busy        = (state == ST_CLEAR);
   assign clear_done  = (state == ST_DONE);

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (disp_slot) begin
         mem_addr = disp_addr;
      end else if (state == ST_CLEAR) begin
         mem_addr  = clr_ptr;
         mem_we    = 1'b1;
         mem_wdata = clr_color;
      end else if (wr_fire && wr_in_range) begin
         mem_addr  = wr_addr;
         mem_we    = 1'b1;
         mem_wdata = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         clr_ptr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (clear_req) begin
                  state   <= ST_CLEAR;
                  clr_ptr <= '0;
               end
            end
            ST_CLEAR: begin
               if (!disp_slot) begin
                  if (clr_ptr == FB_LAST) begin
                     state <= ST_DONE;
                  end else begin
                     clr_ptr <= clr_ptr + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && clear_req) begin
         clr_color <= clear_color;
      end
   end

   // Stage p1: RAM data for the slot fetched last cycle is valid now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         pixel  <= '0;
      end else begin
         vld_p1 <= disp_slot;
         if (col[1:0] == 2'd3) begin
            pixel <= vld_p1 ? mem_rdata : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_stall_cnt <= 16'd0;
         wr_oob       <= 1'b0;
      end else begin
         if (wr_valid && !wr_ready) begin
            wr_stall_cnt <= sat_inc16(wr_stall_cnt);
         end
         if (wr_fire && !wr_in_range) begin
            wr_oob <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: drives VGA counters, models the frame RAM, and compares
// against a screen-level reference (what each pixel of the 640x480 view should show).
module tb_fb_arbiter;
   localparam int PIX_W   = 4;
   localparam int FB_W    = 160;
   localparam int FB_H    = 120;
   localparam int ADDR_W  = 15;
   localparam int FB_SIZE = FB_W * FB_H;
   localparam int H_TOT   = 800;
   localparam int V_TOT   = 525;
   localparam int H_VIS   = 640;
   localparam int V_VIS   = 480;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [9:0]        col;
   logic [9:0]        row;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic              clear_req;
   logic [PIX_W-1:0]  clear_color;
   logic              busy;
   logic              clear_done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [PIX_W-1:0]  mem_wdata;
   logic [PIX_W-1:0]  mem_rdata;
   logic [PIX_W-1:0]  pixel;
   logic [15:0]       wr_stall_cnt;
   logic              wr_oob;

   logic              preload;
   logic [PIX_W-1:0]  ram [0:(1<<ADDR_W)-1];
   logic [PIX_W-1:0]  exp_fb [0:FB_SIZE-1];
   int                checks = 0;
   int                passed = 0;
   int                stall_exp = 0;

   always #5 clk = ~clk;

   fb_arbiter #(
      .PIX_W (PIX_W),
      .FB_W  (FB_W),
      .FB_H  (FB_H),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .col         (col),
      .row         (row),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .clear_req   (clear_req),
      .clear_color (clear_color),
      .busy        (busy),
      .clear_done  (clear_done),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .pixel       (pixel),
      .wr_stall_cnt(wr_stall_cnt),
      .wr_oob      (wr_oob)
   );

   // Single-port synchronous RAM with a registered read.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= PIX_W'(i);
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) passed++;
      else begin
         $error("FAIL %s at row %0d col %0d: observed %0h expected %0h", tag, row, col, obs, want);
      end
   endtask

   function automatic logic model_vis(input int r, input int c);
      return (r < V_VIS) && (c < H_VIS);
   endfunction

   // Linear position two pixels ahead in the 800x525 raster.
   function automatic int model_ahead(input int r, input int c);
      return (r * H_TOT + c + 2) % (H_TOT * V_TOT);
   endfunction

   function automatic logic model_slot(input int r, input int c);
      int q;
      q = model_ahead(r, c);
      return (c % 4 == 2) && model_vis(q / H_TOT, q % H_TOT);
   endfunction

   function automatic int model_disp_addr(input int r, input int c);
      int q;
      q = model_ahead(r, c);
      return ((q / H_TOT) / 4) * FB_W + (q % H_TOT) / 4;
   endfunction

   function automatic logic [PIX_W-1:0] model_pix(input int r, input int c);
      if (!model_vis(r, c)) return '0;
      return exp_fb[(r / 4) * FB_W + c / 4];
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
      if (col == 10'd799) begin
         col = 10'd0;
         row = (row == 10'd524) ? 10'd0 : row + 10'd1;
      end else begin
         col = col + 10'd1;
      end
   endtask

   task automatic set_pos(input int p);
      int q;
      q = (p + H_TOT * V_TOT) % (H_TOT * V_TOT);
      row = 10'(q / H_TOT);
      col = 10'(q % H_TOT);
   endtask

   // Runs n cycles with the arbiter expected idle, checking port sharing and
   // (for one chosen row) the displayed pixel against the screen model.
   task automatic run_cycles(input int n, input int pix_row);
      logic rdy;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rdy = !model_slot(int'(row), int'(col));
         check("wr_ready", 32'(wr_ready), 32'(rdy));
         if (int'(row) == pix_row) check("pixel", 32'(pixel), 32'(model_pix(int'(row), int'(col))));
         if (!rdy) begin
            check("slot_we", 32'(mem_we), 0);
            check("slot_addr", 32'(mem_addr), model_disp_addr(int'(row), int'(col)));
            if (wr_valid) stall_exp++;
         end else if (wr_valid) begin
            check("wr_we", 32'(mem_we), 1);
            check("wr_addr", 32'(mem_addr), 32'(wr_addr));
            check("wr_data", 32'(mem_wdata), 32'(wr_data));
            if (int'(wr_addr) < FB_SIZE) exp_fb[wr_addr] = wr_data;
         end else begin
            check("idle_we", 32'(mem_we), 0);
            check("idle_addr", 32'(mem_addr), 0);
         end
         next_cycle();
      end
   endtask

   task automatic scan_row(input int r);
      set_pos(r * H_TOT - 4);
      run_cycles(H_TOT + 4, r);
   endtask

   task automatic show_check(input int r, input int c, input logic [PIX_W-1:0] want, input string tag);
      set_pos(r * H_TOT + 4 * (c / 4) - 2);
      for (int i = 0; i < 8 && !(int'(row) == r && int'(col) == c); i++) next_cycle();
      @(negedge clk);
      check(tag, 32'(pixel), 32'(want));
      next_cycle();
   endtask

   task automatic do_write(input int addr, input logic [PIX_W-1:0] data, input logic in_range);
      wr_addr  = ADDR_W'(addr);
      wr_data  = data;
      wr_valid = 1'b1;
      @(negedge clk);
      check("wreq_ready", 32'(wr_ready), 32'(!model_slot(int'(row), int'(col))));
      check("wreq_we", 32'(mem_we), 32'(in_range));
      if (in_range) begin
         check("wreq_addr", 32'(mem_addr), addr);
         check("wreq_data", 32'(mem_wdata), 32'(data));
         exp_fb[addr] = data;
      end
      next_cycle();
      wr_valid = 1'b0;
   endtask

   initial begin
      logic got;
      int   exp_ptr;
      rst_n       = 1'b0;
      preload     = 1'b1;
      col         = 10'd0;
      row         = 10'd0;
      wr_valid    = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      clear_req   = 1'b0;
      clear_color = '0;
      for (int i = 0; i < FB_SIZE; i++) exp_fb[i] = PIX_W'(i);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pixel", 32'(pixel), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(clear_done), 0);
      check("rst_stall", 32'(wr_stall_cnt), 0);
      check("rst_oob", 32'(wr_oob), 0);
      preload = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Preloaded image: sampled rows across the frame, including blanking.
      scan_row(0);
      scan_row(5);
      scan_row(119);
      scan_row(479);
      scan_row(480);
      scan_row(524);
      show_check(0, 0, 4'h0, "pix_r0c0");
      show_check(5, 9, 4'h2, "pix_r5c9");
      show_check(200, 700, 4'h0, "pix_hblank");

      // Game port held valid across two visible lines (rewriting the same value).
      set_pos(10 * H_TOT);
      wr_addr  = ADDR_W'(5);
      wr_data  = 4'h5;
      wr_valid = 1'b1;
      run_cycles(2 * H_TOT, 10);
      wr_valid = 1'b0;
      @(negedge clk);
      check("stall_cnt", 32'(wr_stall_cnt), stall_exp);
      check("oob_before", 32'(wr_oob), 0);
      next_cycle();

      // Last buffer address, seen at the bottom-right block.
      set_pos(490 * H_TOT + 100);
      do_write(FB_SIZE - 1, 4'hA, 1'b1);
      for (int r = 476; r < 480; r++) scan_row(r);
      show_check(479, 639, 4'hA, "pix_last_blk");
      show_check(476, 636, 4'hA, "pix_last_blk_top");

      // Out-of-range write is accepted but never reaches the RAM.
      set_pos(490 * H_TOT + 200);
      do_write(FB_SIZE, 4'h3, 1'b0);
      @(negedge clk);
      check("oob_set", 32'(wr_oob), 1);
      next_cycle();
      do_write(0, 4'h0, 1'b1);
      @(negedge clk);
      check("oob_sticky", 32'(wr_oob), 1);
      next_cycle();

      // Whole-buffer clear to 5, with an ignored second request part-way through.
      set_pos(520 * H_TOT);
      clear_color = 4'h5;
      clear_req   = 1'b1;
      @(negedge clk);
      check("clr_req_busy", 32'(busy), 0);
      next_cycle();
      clear_req   = 1'b0;
      clear_color = 4'h9;
      got     = 1'b0;
      exp_ptr = 0;
      for (int i = 0; i < 40000 && !got; i++) begin
         @(negedge clk);
         if (clear_done) begin
            got = 1'b1;
            check("done_busy", 32'(busy), 0);
            check("done_we", 32'(mem_we), 0);
         end else begin
            check("clr_busy", 32'(busy), 1);
            check("clr_ready", 32'(wr_ready), 0);
            if (mem_we) begin
               check("clr_addr", 32'(mem_addr), exp_ptr);
               check("clr_data", 32'(mem_wdata), 32'h5);
               exp_ptr++;
            end
         end
         next_cycle();
         clear_req = (i == 200);
         if (i == 200) clear_color = 4'h7;
      end
      clear_req = 1'b0;
      check("clr_done_seen", 32'(got), 1);
      check("clr_we_count", exp_ptr, FB_SIZE);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_done", 32'(clear_done), 0);
         check("post_busy", 32'(busy), 0);
         next_cycle();
      end
      for (int i = 0; i < FB_SIZE; i++) exp_fb[i] = 4'h5;
      scan_row(0);
      scan_row(240);
      scan_row(479);
      show_check(479, 639, 4'h5, "pix_cleared");

      // Reset lands in the middle of a second clear.
      set_pos(100 * H_TOT);
      clear_color = 4'h3;
      clear_req   = 1'b1;
      next_cycle();
      clear_req = 1'b0;
      repeat (500) next_cycle();
      @(negedge clk);
      check("clr2_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_pixel", 32'(pixel), 0);
      check("arst_done", 32'(clear_done), 0);
      check("arst_oob", 32'(wr_oob), 0);
      check("arst_stall", 32'(wr_stall_cnt), 0);
      stall_exp = 0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("rel_done", 32'(clear_done), 0);
         check("rel_busy", 32'(busy), 0);
         check("rel_ready", 32'(wr_ready), 32'(!model_slot(int'(row), int'(col))));
         next_cycle();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
